// File: rtl/switch_repeat_pulser_pkg.sv
// Shared types and default timing for the hold-to-repeat button pulser.
// Defaults assume a 25 MHz system clock.
package switch_repeat_pulser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    // 0.5 s initial hold delay, 100 ms repeat period at 25 MHz
    localparam int unsigned DEF_DELAY_CYCLES  = 12_500_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 2_500_000;

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switch_repeat_pulser_if.sv
// Button-side bundle: debounced level in, step pulse and repeat flag out.
// master drives the switch, slave is the pulser.
interface switch_repeat_pulser_if;
    logic i_Switch;
    logic o_Pulse;
    logic o_Held;

    modport master (
        output i_Switch,
        input  o_Pulse,
        input  o_Held
    );

    modport slave (
        input  i_Switch,
        output o_Pulse,
        output o_Held
    );
endinterface

// File: rtl/switch_repeat_pulser.sv
// Turns a debounced button level into single-cycle step pulses:
// one on press, one after the hold delay, then periodic until release.
module switch_repeat_pulser
    import switch_repeat_pulser_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES  = DEF_DELAY_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    switch_repeat_pulser_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = max_u(DELAY_CYCLES, REPEAT_CYCLES);
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counter value seen on the edge that completes each interval
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             prev_q, prev_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
    logic             press;

    // Next-state, counter and output decisions; release beats terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        held_d  = held_q;
        prev_d  = bus.i_Switch;
        press   = bus.i_Switch && !prev_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                held_d = 1'b0;
                if (press) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!bus.i_Switch) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DELAY_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (!bus.i_Switch) begin
                    held_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                held_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; prev resets high so a held button stays quiet
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign bus.o_Pulse = pulse_q;
    assign bus.o_Held  = held_q;

endmodule

// File: tb/tb_switch_repeat_pulser.sv
// Self-checking bench for switch_repeat_pulser with short timing.
// Table vectors, hand-written corner sequences and a random run vs a model.
module tb_switch_repeat_pulser;

    localparam int unsigned D = 5;
    localparam int unsigned R = 3;

    logic i_Clk;
    logic i_Rst;

    switch_repeat_pulser_if bus ();

    switch_repeat_pulser #(
        .DELAY_CYCLES  (D),
        .REPEAT_CYCLES (R)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic sw;
        logic pulse;
        logic held;
    } vec_t;

    vec_t vecs[$];

    int n_vec;
    int n_bad;

    // Reference model: time since the accepted press edge
    logic m_prev;
    logic m_active;
    int   m_age;
    logic m_pulse;
    logic m_held;

    task automatic model_reset();
        m_prev   = 1'b1;
        m_active = 1'b0;
        m_age    = 0;
        m_pulse  = 1'b0;
        m_held   = 1'b0;
    endtask

    task automatic model_edge(input logic sw);
        if (!m_active) begin
            m_held  = 1'b0;
            m_pulse = sw && !m_prev;
            if (m_pulse) begin
                m_active = 1'b1;
                m_age    = 0;
            end
        end else if (!sw) begin
            m_active = 1'b0;
            m_pulse  = 1'b0;
            m_held   = 1'b0;
        end else begin
            m_age   = m_age + 1;
            m_held  = (m_age >= int'(D));
            m_pulse = (m_age == int'(D)) ||
                      (m_age > int'(D) && ((m_age - int'(D)) % int'(R)) == 0);
        end
        m_prev = sw;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Apply a level, advance one edge, sample just after it
    task automatic step(input logic sw);
        bus.i_Switch = sw;
        @(posedge i_Clk);
        model_edge(sw);
        #1;
    endtask

    task automatic step_chk(input string name, input logic sw,
                            input logic p, input logic h);
        step(sw);
        check({name, ".pulse"}, bus.o_Pulse, p);
        check({name, ".held"}, bus.o_Held, h);
    endtask

    task automatic add(input logic sw, input logic p, input logic h);
        vec_t v;
        v.sw = sw;
        v.pulse = p;
        v.held = h;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Short press: one pulse, no hold
        add(1, 1, 0); add(1, 0, 0); add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0);
        // Continuous hold k..k+19, release at k+20
        add(1, 1, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0);
        add(1, 1, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 1); add(1, 0, 1);
        add(1, 0, 1); add(1, 1, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 1);
        add(1, 0, 1); add(1, 0, 1); add(1, 1, 1); add(1, 0, 1); add(1, 0, 1);
        add(0, 0, 0); add(0, 0, 0); add(0, 0, 0);
        // Release exactly at k+5: release beats terminal count
        add(1, 1, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 0, 0);
        add(0, 0, 0); add(0, 0, 0);
        // Re-press right after returning to idle
        add(1, 1, 0); add(0, 0, 0); add(1, 1, 0); add(0, 0, 0);

        bus.i_Switch = 1'b0;
        i_Rst = 1'b1;
        model_reset();
        #2;
        check("rst.pulse", bus.o_Pulse, 1'b0);
        check("rst.held", bus.o_Held, 1'b0);
        @(posedge i_Clk);
        #3 i_Rst = 1'b0;

        for (int i = 0; i < 10; i++) step_chk("idle", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i].sw, vecs[i].pulse, vecs[i].held);
        end

        // Button held through reset deassertion
        bus.i_Switch = 1'b1;
        #2 i_Rst = 1'b1;
        model_reset();
        #1;
        check("rsthold.pulse", bus.o_Pulse, 1'b0);
        @(posedge i_Clk);
        #3 i_Rst = 1'b0;
        for (int i = 0; i < 4; i++) step_chk("rsthold", 1'b1, 1'b0, 1'b0);
        step_chk("rsthold.rel", 1'b0, 1'b0, 1'b0);
        step_chk("rsthold.press", 1'b1, 1'b1, 1'b0);
        step_chk("rsthold.next", 1'b1, 1'b0, 1'b0);
        step_chk("rsthold.end", 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of REPEAT, on a pulse cycle
        step_chk("midrep.press", 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) step(1'b1);
        step_chk("midrep.k8", 1'b1, 1'b1, 1'b1);
        #2 i_Rst = 1'b1;
        model_reset();
        #1;
        check("midrep.async.pulse", bus.o_Pulse, 1'b0);
        check("midrep.async.held", bus.o_Held, 1'b0);
        #2 i_Rst = 1'b0;
        for (int i = 0; i < 8; i++) step_chk("midrep.hold", 1'b1, 1'b0, 1'b0);
        step_chk("midrep.rel", 1'b0, 1'b0, 1'b0);
        step_chk("midrep.press2", 1'b1, 1'b1, 1'b0);
        step_chk("midrep.end", 1'b0, 1'b0, 1'b0);

        // Random hold lengths against the model, with occasional resets
        for (int b = 0; b < 300; b++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 25));
            for (int c = 0; c < len; c++) begin
                step(lvl);
                check("rand.pulse", bus.o_Pulse, m_pulse);
                check("rand.held", bus.o_Held, m_held);
            end
            if ($urandom_range(0, 29) == 0) begin
                #2 i_Rst = 1'b1;
                model_reset();
                #1;
                check("rand.rst.pulse", bus.o_Pulse, 1'b0);
                check("rand.rst.held", bus.o_Held, 1'b0);
                #2 i_Rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
